karat_mult_hs: RTL

- Parametrised, handshaked successor to the fixed-width Karatsuba multiplier for the MSM datapath.
- Accepts two WIDTH-bit operands with a per-transaction signed/unsigned mode.
- Computes the full 2*WIDTH-bit product with one Karatsuba split, sharing one half-width multiplier over three cycles, then applies the sign.
- Valid/ready on both sides replaces the enable/finish pulse pair; sits between the point-arithmetic sequencer and the field-reduction stage.

---
 rtl/karat_pkg.sv | 22 ++
 rtl/karat_half_mult.sv | 39 +++
 rtl/karat_mult_hs.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/karat_pkg.sv
// karat_pkg: FSM states, width derivations and WIDTH legality check for karat_mult_hs
package karat_pkg;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, COMB, OUT} state_t;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int sum_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int comb_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w % 2 == 0);
  endfunction

endpackage

// File: rtl/karat_half_mult.sv
// karat_half_mult: registered (HW+1)x(HW+1) unsigned multiplier shared across P0..P2
module karat_half_mult
  import karat_pkg::*;
#(
  parameter int WIDTH = 16
)(
  input  logic                         clk,
  input  logic                         reset,
  input  state_t                       i_state,
  input  logic [half_w(WIDTH)-1:0]     i_xl,
  input  logic [half_w(WIDTH)-1:0]     i_xh,
  input  logic [half_w(WIDTH)-1:0]     i_yl,
  input  logic [half_w(WIDTH)-1:0]     i_yh,
  output logic [2*sum_w(WIDTH)-1:0]    o_prod
);

  localparam int SW = sum_w(WIDTH);

  logic [SW-1:0]   w_a;
  logic [SW-1:0]   w_b;
  logic [2*SW-1:0] r_prod;

  // Operand select: low halves in P0, high halves in P1, half sums in P2
  always_comb begin
    w_a = (i_state == P1) ? {1'b0, i_xh} :
          (i_state == P2) ? {1'b0, i_xl} + {1'b0, i_xh} : {1'b0, i_xl};
    w_b = (i_state == P1) ? {1'b0, i_yh} :
          (i_state == P2) ? {1'b0, i_yl} + {1'b0, i_yh} : {1'b0, i_yl};
  end

  // Product register; its value is consumed one state after the operands were selected
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_prod <= '0;
    else        r_prod <= {{SW{1'b0}}, w_a} * {{SW{1'b0}}, w_b};
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/karat_mult_hs.sv
// karat_mult_hs: handshaked one-level Karatsuba multiplier; optional accumulator under KMULT_ACC_EN
module karat_mult_hs
  import karat_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef KMULT_ACC_EN
  , parameter int ACC_GUARD = 8
`endif
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     iX,
  input  logic [WIDTH-1:0]     iY,
  input  logic                 i_signed,
  output logic [2*WIDTH-1:0]   oO,
  output logic                 o_valid,
  input  logic                 i_ready
`ifdef KMULT_ACC_EN
  , input  logic                         i_acc
  , input  logic                         i_acc_clr
  , output logic [2*WIDTH+ACC_GUARD-1:0] oAcc
`endif
);

  localparam int HW = half_w(WIDTH);
  localparam int SW = sum_w(WIDTH);
  localparam int CW = comb_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("karat_mult_hs: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic [WIDTH-1:0] w_xm;
  logic [WIDTH-1:0] w_ym;
  logic            w_neg;
  logic [WIDTH-1:0] r_xm;
  logic [WIDTH-1:0] r_ym;
  logic            r_neg;
  logic [WIDTH-1:0] r_z0;
  logic [WIDTH-1:0] r_z2;
  logic [PW-1:0]   r_o;
  logic [2*SW-1:0] w_prod;
  logic [CW-1:0]   w_z0e;
  logic [CW-1:0]   w_z1e;
  logic [CW-1:0]   w_z2e;
  logic [PW-1:0]   w_mag;
  logic [PW-1:0]   w_res;

  assign w_accept = (r_state == IDLE) && i_valid;
  assign w_xm     = (i_signed && iX[WIDTH-1]) ? -iX : iX;
  assign w_ym     = (i_signed && iY[WIDTH-1]) ? -iY : iY;
  assign w_neg    = i_signed && (iX[WIDTH-1] ^ iY[WIDTH-1]) && (|iX) && (|iY);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs; ready only in IDLE, valid only in OUT
  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = P0;
      end
      P0:   w_next = P1;
      P1:   w_next = P2;
      P2:   w_next = COMB;
      COMB: w_next = OUT;
      OUT: begin
        o_valid = 1'b1;
        if (i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  karat_half_mult #(.WIDTH(WIDTH)) u_half (
    .clk     (clk),
    .reset   (reset),
    .i_state (r_state),
    .i_xl    (r_xm[HW-1:0]),
    .i_xh    (r_xm[WIDTH-1:HW]),
    .i_yl    (r_ym[HW-1:0]),
    .i_yh    (r_ym[WIDTH-1:HW]),
    .o_prod  (w_prod)
  );

  // Combine z2, z1, z0 at full guard width; z1 is read straight from the multiplier in COMB
  always_comb begin
    w_z0e = {{(CW-WIDTH){1'b0}}, r_z0};
    w_z2e = {{(CW-WIDTH){1'b0}}, r_z2};
    w_z1e = {{(CW-2*SW){1'b0}}, w_prod};
    w_mag = PW'((w_z2e << WIDTH) + ((w_z1e - w_z2e - w_z0e) << HW) + w_z0e);
    w_res = r_neg ? -w_mag : w_mag;
  end

  // Operand capture at accept, partial product capture, result register held through OUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xm  <= '0;
      r_ym  <= '0;
      r_neg <= 1'b0;
      r_z0  <= '0;
      r_z2  <= '0;
      r_o   <= '0;
    end else begin
      if (w_accept) begin
        r_xm  <= w_xm;
        r_ym  <= w_ym;
        r_neg <= w_neg;
      end
      if (r_state == P1)   r_z0 <= w_prod[WIDTH-1:0];
      if (r_state == P2)   r_z2 <= w_prod[WIDTH-1:0];
      if (r_state == COMB) r_o  <= w_res;
    end
  end

  assign oO = r_o;

`ifdef KMULT_ACC_EN
  localparam int AW = PW + ACC_GUARD;

  logic          r_acc_en;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_sext;

  // Only a nonzero signed-negative result is negative, so r_neg is the extension bit
  assign w_sext = {{ACC_GUARD{r_neg}}, w_res};

  // Accumulate on the COMB->OUT edge so oAcc moves together with o_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_en <= 1'b0;
      r_acc    <= '0;
    end else begin
      if (w_accept) r_acc_en <= i_acc;
      if (r_state == IDLE && i_acc_clr)     r_acc <= '0;
      else if (r_state == COMB && r_acc_en) r_acc <= r_acc + w_sext;
    end
  end

  assign oAcc = r_acc;
`endif

endmodule
